// File: rtl/uart_cmd_rx_if.sv
// Controller-side request/response bundle for the UART command receiver.
// master = command receiver (issues requests), slave = controller/response sink.
interface uart_cmd_rx_if #(
   parameter int ADDR_W = 26
);
   logic              busy;
   logic              data_ready;
   logic [15:0]       dout;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       din;
   logic              wr;
   logic              rd;
   logic              rsp_valid;
   logic [15:0]       rsp_data;
   logic              rsp_err;
   logic              frame_err;

   modport master (
      input  busy, data_ready, dout,
      output addr, din, wr, rd, rsp_valid, rsp_data, rsp_err, frame_err
   );

   modport slave (
      output busy, data_ready, dout,
      input  addr, din, wr, rd, rsp_valid, rsp_data, rsp_err, frame_err
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver + ASCII hex command parser issuing single-word wr/rd requests.
// Requests wait while busy is high; bytes arriving during issue/wait are dropped.
module uart_cmd_rx #(
   parameter int CLK_FREQ   = 78_750_000,
   parameter int BAUD       = 115200,
   parameter int ADDR_W     = 26,
   parameter int RD_TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          uart_rxp,
   uart_cmd_rx_if.master bus
);
   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int TW   = $clog2(RD_TIMEOUT + 1);
   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [TW-1:0] TMO     = TW'(RD_TIMEOUT);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_ISSUE, P_WAIT, P_ERR} p_state_t;

   rx_state_t         rx_state_q, rx_state_d;
   logic              rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_vld_q, byte_vld_d;
   logic              ferr_q, ferr_d;

   p_state_t          p_state_q, p_state_d;
   logic              is_wr_q, is_wr_d;
   logic              have_dig_q, have_dig_d;
   logic [ADDR_W-1:0] addr_acc_q, addr_acc_d, addr_q, addr_d;
   logic [15:0]       data_acc_q, data_acc_d, din_q, din_d;
   logic              wr_q, wr_d, rd_q, rd_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [15:0]       rsp_data_q, rsp_data_d;
   logic [TW-1:0]     tmo_q, tmo_d;

   function automatic logic [4:0] hex_nib(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
      if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
      return 5'd0;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_meta_q  <= uart_rxp;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_vld_q <= byte_vld_d;
         ferr_q     <= ferr_d;
      end
   end

   // Falling-edge start detect, mid-bit sampling; return to idle right after the stop sample.
   always_comb begin
      rx_state_d = rx_state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_vld_d = 1'b0;
      ferr_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: if (cnt_q == HALF_M1) begin
            cnt_d      = '0;
            bit_d      = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt_q == DIV_M1) begin
            cnt_d   = '0;
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (cnt_q == DIV_M1) begin
            cnt_d      = '0;
            rx_state_d = RX_IDLE;
            byte_vld_d = rx_sync_q;
            ferr_d     = !rx_sync_q;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_state_q   <= P_IDLE;
         is_wr_q     <= 1'b0;
         have_dig_q  <= 1'b0;
         addr_acc_q  <= '0;
         data_acc_q  <= '0;
         addr_q      <= '0;
         din_q       <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         tmo_q       <= '0;
      end else begin
         p_state_q   <= p_state_d;
         is_wr_q     <= is_wr_d;
         have_dig_q  <= have_dig_d;
         addr_acc_q  <= addr_acc_d;
         data_acc_q  <= data_acc_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
         tmo_q       <= tmo_d;
      end
   end

   logic [4:0] nib;
   logic       is_eol, is_spc, bad;

   always_comb begin
      p_state_d   = p_state_q;
      is_wr_d     = is_wr_q;
      have_dig_d  = have_dig_q;
      addr_acc_d  = addr_acc_q;
      data_acc_d  = data_acc_q;
      addr_d      = addr_q;
      din_d       = din_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      tmo_d       = tmo_q;
      bad         = 1'b0;
      nib         = hex_nib(shift_q);
      is_eol      = (shift_q == 8'h0D) || (shift_q == 8'h0A);
      is_spc      = (shift_q == 8'h20);

      if (wr_q) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = din_q;
      end

      case (p_state_q)
         P_IDLE: if (byte_vld_q) begin
            if (shift_q == 8'h57 || shift_q == 8'h77 || shift_q == 8'h52 || shift_q == 8'h72) begin
               is_wr_d    = (shift_q == 8'h57 || shift_q == 8'h77);
               addr_acc_d = '0;
               have_dig_d = 1'b0;
               p_state_d  = P_ADDR;
            end else if (!is_eol && !is_spc) begin
               p_state_d = P_ERR;
            end
         end
         P_ADDR: if (byte_vld_q) begin
            if (nib[4]) begin
               addr_acc_d = {addr_acc_q[ADDR_W-5:0], nib[3:0]};
               have_dig_d = 1'b1;
            end else if (is_spc && is_wr_q && have_dig_q) begin
               data_acc_d = '0;
               have_dig_d = 1'b0;
               p_state_d  = P_DATA;
            end else if (is_eol && !is_wr_q && have_dig_q) begin
               addr_d    = addr_acc_q;
               p_state_d = P_ISSUE;
            end else begin
               bad = 1'b1;
            end
         end
         P_DATA: if (byte_vld_q) begin
            if (nib[4]) begin
               data_acc_d = {data_acc_q[11:0], nib[3:0]};
               have_dig_d = 1'b1;
            end else if (is_eol && have_dig_q) begin
               addr_d    = addr_acc_q;
               din_d     = data_acc_q;
               p_state_d = P_ISSUE;
            end else begin
               bad = 1'b1;
            end
         end
         P_ISSUE: if (!bus.busy) begin
            wr_d      = is_wr_q;
            rd_d      = !is_wr_q;
            tmo_d     = '0;
            p_state_d = is_wr_q ? P_IDLE : P_WAIT;
         end
         P_WAIT: begin
            // A strobe coincident with rd cannot belong to this request.
            if (bus.data_ready && !rd_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = bus.dout;
               p_state_d   = P_IDLE;
            end else if (tmo_q == TMO) begin
               rsp_err_d = 1'b1;
               p_state_d = P_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         P_ERR: if (byte_vld_q && is_eol) begin
            rsp_err_d = 1'b1;
            p_state_d = P_IDLE;
         end
         default: p_state_d = P_IDLE;
      endcase

      // A rejected line terminator closes the command at once; anything else waits for one.
      if (bad) begin
         if (is_eol) begin
            rsp_err_d = 1'b1;
            p_state_d = P_IDLE;
         end else begin
            p_state_d = P_ERR;
         end
      end
   end

   assign bus.addr      = addr_q;
   assign bus.din       = din_q;
   assign bus.wr        = wr_q;
   assign bus.rd        = rd_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.frame_err = ferr_q;
endmodule
